// File: rtl/small_divider.sv
// Fully pipelined unsigned restoring divider: c = floor(a / b), one quotient bit per stage.
// Accepts a new operand pair every cycle; the quotient appears WIDTH cycles after sampling.
module small_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    input  logic             reset_n
);

    // Index 0 is the operand capture stage; stage i resolves quotient bit WIDTH-i.
    logic [WIDTH-1:0] dvd_q [WIDTH];
    logic [WIDTH-1:0] dvd_d [WIDTH];
    logic [WIDTH-1:0] dvs_q [WIDTH];
    logic [WIDTH-1:0] dvs_d [WIDTH];
    logic [WIDTH:0]   rem_q [WIDTH];
    logic [WIDTH:0]   rem_d [WIDTH];
    logic [WIDTH-1:0] quo_q [WIDTH+1];
    logic [WIDTH-1:0] quo_d [WIDTH+1];
    logic [WIDTH-1:0] vld_q;
    logic [WIDTH-1:0] vld_d;
    logic [WIDTH+1:0] shf   [1:WIDTH];
    logic [WIDTH:1]   brw;

    always_comb begin
        dvd_d[0] = a;
        dvs_d[0] = b;
        rem_d[0] = '0;
        quo_d[0] = '0;
        vld_d[0] = 1'b1;
        brw      = '0;
        for (int i = 1; i <= WIDTH; i++) begin
            shf[i]   = {rem_q[i-1], dvd_q[i-1][WIDTH-1]};
            brw[i]   = shf[i] < {2'b00, dvs_q[i-1]};
            quo_d[i] = {quo_q[i-1][WIDTH-2:0], ~brw[i]};
        end
        // Slots captured during reset carry no operands and must leave as zero.
        if (!vld_q[WIDTH-1]) begin
            quo_d[WIDTH] = '0;
        end
        for (int i = 1; i < WIDTH; i++) begin
            rem_d[i] = brw[i] ? shf[i][WIDTH:0]
                              : (WIDTH+1)'(shf[i] - {2'b00, dvs_q[i-1]});
            dvd_d[i] = dvd_q[i-1] << 1;
            dvs_d[i] = dvs_q[i-1];
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i <= WIDTH; i++) begin
                quo_q[i] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                dvd_q[i] <= '0;
                dvs_q[i] <= '0;
                rem_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i <= WIDTH; i++) begin
                quo_q[i] <= quo_d[i];
            end
            for (int i = 0; i < WIDTH; i++) begin
                dvd_q[i] <= dvd_d[i];
                dvs_q[i] <= dvs_d[i];
                rem_q[i] <= rem_d[i];
            end
        end
    end

    assign c = quo_q[WIDTH];

endmodule

// File: tb/tb_small_divider.sv
// Bench for small_divider: directed WIDTH=8 vectors plus an exhaustive WIDTH=4 sweep,
// both checked every cycle against a delay-line model of floor(a/b).
module tb_small_divider;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] a8, b8, c8;
    logic [3:0] a4, b4, c4;

    always #5 clock = ~clock;

    small_divider #(.WIDTH(8)) dut8 (
        .clock  (clock),
        .a      (a8),
        .b      (b8),
        .c      (c8),
        .reset_n(reset_n)
    );

    small_divider #(.WIDTH(4)) dut4 (
        .clock  (clock),
        .a      (a4),
        .b      (b4),
        .c      (c4),
        .reset_n(reset_n)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;
    int hist8 [0:8];
    int hist4 [0:4];

    function automatic int ref_q(int x, int y, int w);
        if (y == 0) return (1 << w) - 1;
        return x / y;
    endfunction

    task automatic check(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: quotient of each sampled pair emerges WIDTH edges later; reset empties it to zeros.
    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i <= 8; i++) hist8[i] = 0;
            for (int i = 0; i <= 4; i++) hist4[i] = 0;
            armed = 1'b1;
        end else begin
            for (int i = 8; i > 0; i--) hist8[i] = hist8[i-1];
            hist8[0] = ref_q(int'(a8), int'(b8), 8);
            for (int i = 4; i > 0; i--) hist4[i] = hist4[i-1];
            hist4[0] = ref_q(int'(a4), int'(b4), 4);
        end
        #1;
        if (armed) begin
            check("model_w8", int'(c8), hist8[8]);
            check("model_w4", int'(c4), hist4[4]);
        end
    end

    task automatic hold_check(int x, int y, int exp);
        @(negedge clock);
        a8 = 8'(x);
        b8 = 8'(y);
        @(posedge clock);
        repeat (8) @(posedge clock);
        #2;
        check("hold_result", int'(c8), exp);
        $display("hold a=%0d b=%0d -> c=%0d (want %0d)", x, y, c8, exp);
        @(posedge clock);
    endtask

    int sa [4] = '{200, 9, 255, 13};
    int sb [4] = '{3, 9, 16, 4};
    int se [4] = '{66, 1, 15, 3};

    initial begin
        reset_n = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #2;
        check("reset_c_zero", int'(c8), 0);
        $display("reset released c=%0d", c8);

        hold_check(8, 4, 2);
        hold_check(123, 5, 24);
        hold_check(255, 1, 255);
        hold_check(1, 5, 0);
        hold_check(0, 10, 0);
        hold_check(77, 0, 255);
        hold_check(100, 7, 14);

        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            a8 = 8'(sa[i]);
            b8 = 8'(sb[i]);
            @(posedge clock);
        end
        repeat (5) @(posedge clock);
        #2;
        check("stream_0", int'(c8), se[0]);
        $display("stream a=%0d b=%0d -> c=%0d", sa[0], sb[0], c8);
        for (int i = 1; i < 4; i++) begin
            @(posedge clock);
            #2;
            check("stream_n", int'(c8), se[i]);
            $display("stream a=%0d b=%0d -> c=%0d", sa[i], sb[i], c8);
        end

        // Put four quotients in flight, then reset before any reaches c.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            a8 = 8'(sa[i]);
            b8 = 8'(sb[i]);
            @(posedge clock);
        end
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #2;
        check("midflight_reset_c", int'(c8), 0);
        @(negedge clock);
        reset_n = 1'b1;
        a8 = 8'd50;
        b8 = 8'd5;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #2;
            check("no_stale_quotient", int'(c8), 0);
        end
        @(posedge clock);
        #2;
        check("first_after_reset", int'(c8), 10);
        $display("after reset a=50 b=5 -> c=%0d", c8);

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                @(negedge clock);
                a4 = 4'(x);
                b4 = 4'(y);
            end
        end
        repeat (6) @(posedge clock);
        $display("exhaustive width-4 sweep of 256 pairs issued");

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
